// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
// Owner tags, arbiter FSM states and starvation counter width.
package dmem_arb_pkg;

  localparam int STARVE_CNT_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_EXT
  } own_e;

  typedef enum logic {
    ARB_PRI_CPU,
    ARB_FORCE_EXT
  } arb_st_e;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating wait counter with threshold compare for the ext port.
// Only built when DMEM_ARB_STARVE_GUARD_EN is defined.
`ifdef DMEM_ARB_STARVE_GUARD_EN
module dmem_arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic arst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_hit
);

  localparam logic [STARVE_CNT_W-1:0] HIT =
    STARVE_CNT_W'(LIMIT - 1);

  logic [STARVE_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_hit = (r_cnt == HIT);

endmodule
`endif

// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter: MEM stage first, ext in idle cycles.
// DMEM_ARB_STARVE_GUARD_EN adds a forced ext grant that stalls the CPU.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
`ifdef DMEM_ARB_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = 8
`endif
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              cpu_ren,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_valid,
  output logic              ext_ready,
  input  logic              ext_wen,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic w_cpu_req;
  logic w_force;
  logic w_ext_gnt;
  logic w_cpu_gnt;
  own_e r_rd_own;

  assign w_cpu_req = cpu_ren | cpu_wen;

  // Grants are masked during reset so nothing reaches memory.
  assign w_ext_gnt = arst_n & ext_valid &
                     (~w_cpu_req | w_force);
  assign w_cpu_gnt = arst_n & w_cpu_req & ~w_ext_gnt;
  assign ext_ready = w_ext_gnt;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  arb_st_e r_state;
  logic    w_hit;

  dmem_arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .i_inc  (ext_valid & ~w_ext_gnt),
    .i_clr  (~ext_valid | w_ext_gnt),
    .o_hit  (w_hit)
  );

  assign w_force   = (r_state == ARB_FORCE_EXT);
  assign cpu_stall = w_cpu_req & w_ext_gnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= ARB_PRI_CPU;
    end else begin
      unique case (r_state)
        ARB_PRI_CPU: begin
          if (w_hit && ext_valid && w_cpu_req)
            r_state <= ARB_FORCE_EXT;
        end
        ARB_FORCE_EXT: r_state <= ARB_PRI_CPU;
        default:       r_state <= ARB_PRI_CPU;
      endcase
    end
  end
`else
  assign w_force   = 1'b0;
  assign cpu_stall = 1'b0;
`endif

  always_comb begin
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_wdata = '0;
    unique case (1'b1)
      w_cpu_gnt: begin
        mem_addr  = cpu_addr;
        mem_wen   = cpu_wen;
        mem_ren   = cpu_ren;
        mem_wdata = cpu_wdata;
      end
      w_ext_gnt: begin
        mem_addr  = ext_addr;
        mem_wen   = ext_wen;
        mem_ren   = ~ext_wen;
        mem_wdata = ext_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rd_own <= OWN_NONE;
    end else begin
      unique case (1'b1)
        (w_cpu_gnt & cpu_ren):  r_rd_own <= OWN_CPU;
        (w_ext_gnt & ~ext_wen): r_rd_own <= OWN_EXT;
        default:                r_rd_own <= OWN_NONE;
      endcase
    end
  end

  assign cpu_rvalid = (r_rd_own == OWN_CPU);
  assign ext_rvalid = (r_rd_own == OWN_EXT);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign ext_rdata  = ext_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized scoreboard bench for dmem_port_arbiter.
// Follows DMEM_ARB_STARVE_GUARD_EN to pick the expected arbitration.
module tb_dmem_port_arbiter;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        cpu_ren, cpu_wen;
  logic [63:0] cpu_addr, cpu_wdata;
  logic        cpu_stall, cpu_rvalid;
  logic [63:0] cpu_rdata;
  logic        ext_valid, ext_ready, ext_wen;
  logic [63:0] ext_addr, ext_wdata;
  logic        ext_rvalid;
  logic [63:0] ext_rdata;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_wen, mem_ren;
  logic [63:0] mem_rdata = '0;

  dmem_port_arbiter dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .cpu_ren    (cpu_ren),
    .cpu_wen    (cpu_wen),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ext_valid  (ext_valid),
    .ext_ready  (ext_ready),
    .ext_wen    (ext_wen),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_ren    (mem_ren),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h",
               nm, act, exp);
    end
  endtask

  // Golden memory contents and the memory device the DUT talks to.
  logic [63:0] ref_mem [32];
  logic [63:0] env_mem [32];
  bit          env_done = 1'b0;

  always @(posedge clk) begin
    if (!env_done) begin
      for (int i = 0; i < 32; i++) env_mem[i] <= ref_mem[i];
      env_done <= 1'b1;
    end else begin
      if (mem_ren) mem_rdata <= env_mem[mem_addr[7:3]];
      if (mem_wen) env_mem[mem_addr[7:3]] <= mem_wdata;
    end
  end

  logic [63:0] cpu_q [$];
  logic [63:0] ext_q [$];

  always @(negedge clk) begin
    logic        ev;
    logic [63:0] ed;
    if (arst_n) begin
      ev = (cpu_q.size() != 0);
      ed = ev ? cpu_q.pop_front() : 64'd0;
      chk("cpu_rvalid", 64'(cpu_rvalid), 64'(ev));
      chk("cpu_rdata", cpu_rdata, ed);
      ev = (ext_q.size() != 0);
      ed = ev ? ext_q.pop_front() : 64'd0;
      chk("ext_rvalid", 64'(ext_rvalid), 64'(ev));
      chk("ext_rdata", ext_rdata, ed);
    end
  end

  logic        e_v = 1'b0, e_w = 1'b0;
  logic [63:0] e_a = '0, e_d = '0;
  int          ext_mode = 0;
  int          m_wait = 0;
  bit          m_forced = 1'b0;
  bit          m_stalled = 1'b0;
  logic        h_r, h_w;
  logic [63:0] h_a, h_d;
  logic        d_ready, d_stall;

  task automatic new_ext(input bit rd_only);
    e_v = 1'b1;
    e_w = rd_only ? 1'b0 : 1'($urandom_range(0, 1));
    e_a = 64'($urandom_range(0, 31)) << 3;
    e_d = {$urandom, $urandom};
  endtask

  task automatic ext_next();
    if (ext_mode == 1) begin
      if (!e_v) begin
        if ($urandom_range(0, 1) == 1) new_ext(1'b0);
      end else if ($urandom_range(0, 15) == 0) begin
        e_v = 1'b0;
      end
    end else if (ext_mode == 2) begin
      if (!e_v) new_ext(1'b1);
    end
  endtask

  // One clock: drive, check grant and memory port, update model.
  task automatic drive_cycle(input logic cr, input logic cw,
                             input logic [63:0] ca,
                             input logic [63:0] cd);
    logic creq, eg, cg, st, nf, xr, xw;
    logic [63:0] xa, xd;
    if (m_stalled) begin
      cr = h_r; cw = h_w; ca = h_a; cd = h_d;
    end
    cpu_ren = cr; cpu_wen = cw;
    cpu_addr = ca; cpu_wdata = cd;
    ext_valid = e_v; ext_wen = e_w;
    ext_addr = e_a; ext_wdata = e_d;
    creq = cr | cw;
    eg = e_v && (!creq || m_forced);
    cg = creq && !eg;
    st = creq && eg;
    xr = 1'b0; xw = 1'b0; xa = '0; xd = '0;
    if (cg) begin
      xr = cr; xw = cw; xa = ca; xd = cd;
    end else if (eg) begin
      xr = !e_w; xw = e_w; xa = e_a; xd = e_d;
    end
    @(negedge clk);
    d_ready = ext_ready;
    d_stall = cpu_stall;
    chk("ext_ready", 64'(ext_ready), 64'(eg));
    chk("cpu_stall", 64'(cpu_stall), 64'(st));
    chk("mem_ren", 64'(mem_ren), 64'(xr));
    chk("mem_wen", 64'(mem_wen), 64'(xw));
    chk("mem_addr", mem_addr, xa);
    chk("mem_wdata", mem_wdata, xd);
    @(posedge clk);
    if (cg && cw) ref_mem[ca[7:3]] = cd;
    if (cg && cr) cpu_q.push_back(ref_mem[ca[7:3]]);
    if (eg) begin
      if (e_w) ref_mem[e_a[7:3]] = e_d;
      else     ext_q.push_back(ref_mem[e_a[7:3]]);
    end
`ifdef DMEM_ARB_STARVE_GUARD_EN
    nf = !m_forced && e_v && creq && (m_wait == LIMIT - 1);
`else
    nf = 1'b0;
`endif
    if (e_v && !eg) m_wait = (m_wait < 255) ? m_wait + 1 : 255;
    else            m_wait = 0;
    m_forced = nf;
    m_stalled = st;
    h_r = cr; h_w = cw; h_a = ca; h_d = cd;
    if (eg) e_v = 1'b0;
    ext_next();
    #1;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 1'b0, 64'd0, 64'd0);
  endtask

  task automatic rand_cycle(input bit always_req);
    int k;
    logic [63:0] a, d;
    k = always_req ? $urandom_range(1, 3) : $urandom_range(0, 3);
    a = 64'($urandom_range(0, 31)) << 3;
    d = {$urandom, $urandom};
    drive_cycle(k == 1 || k == 3, k == 2, a, d);
  endtask

  task automatic chk_reset_outs();
    chk("rst_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
    chk("rst_ext_rvalid", 64'(ext_rvalid), 64'd0);
    chk("rst_cpu_stall", 64'(cpu_stall), 64'd0);
    chk("rst_ext_ready", 64'(ext_ready), 64'd0);
    chk("rst_mem_ren", 64'(mem_ren), 64'd0);
    chk("rst_mem_wen", 64'(mem_wen), 64'd0);
    chk("rst_cpu_rdata", cpu_rdata, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ngr, nst, first;
    int exp_gr, exp_first;
    for (int i = 0; i < 32; i++) ref_mem[i] = {$urandom, $urandom};
    ref_mem[8] = 64'hA5;
    arst_n = 1'b0;
    cpu_ren = 1'b0; cpu_wen = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    ext_valid = 1'b1; ext_wen = 1'b0;
    ext_addr = '0; ext_wdata = '0;
    #3;
    chk_reset_outs();
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;

    // CPU read alone
    drive_cycle(1'b1, 1'b0, 64'h40, 64'd0);
    idle_cycle();

    // ext write then read, CPU idle
    e_v = 1'b1; e_w = 1'b1; e_a = 64'h80; e_d = 64'h1234;
    idle_cycle();
    e_v = 1'b1; e_w = 1'b0; e_a = 64'h80; e_d = 64'h0;
    idle_cycle();
    idle_cycle();

    // Same-cycle CPU read and ext read
    e_v = 1'b1; e_w = 1'b0; e_a = 64'h80;
    drive_cycle(1'b1, 1'b0, 64'h40, 64'd0);
    idle_cycle();
    idle_cycle();

    // CPU busy every cycle with ext always pending
    ext_mode = 2;
    new_ext(1'b1);
    ngr = 0; nst = 0; first = 0;
    for (int i = 1; i <= 100; i++) begin
      rand_cycle(1'b1);
      if (d_ready) begin
        ngr++;
        if (first == 0) first = i;
      end
      if (d_stall) nst++;
    end
`ifdef DMEM_ARB_STARVE_GUARD_EN
    exp_gr = 100 / (LIMIT + 1);
    exp_first = LIMIT + 1;
`else
    exp_gr = 0;
    exp_first = 0;
`endif
    chk("starve_grants", 64'(ngr), 64'(exp_gr));
    chk("starve_first", 64'(first), 64'(exp_first));
    chk("starve_stalls", 64'(nst), 64'(exp_gr));
    ext_mode = 0;
    repeat (3) idle_cycle();

    // Random traffic
    ext_mode = 1;
    repeat (400) rand_cycle(1'b0);
    ext_mode = 0;
    repeat (3) idle_cycle();

    // Reset while a CPU read is granted and another is in flight
    drive_cycle(1'b1, 1'b0, 64'h40, 64'd0);
    cpu_ren = 1'b1; cpu_addr = 64'h48;
    ext_valid = 1'b1; ext_wen = 1'b0;
    #2;
    arst_n = 1'b0;
    cpu_q.delete();
    ext_q.delete();
    #1;
    chk_reset_outs();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs();
    m_wait = 0; m_forced = 1'b0; m_stalled = 1'b0;
    e_v = 1'b0;
    arst_n = 1'b1;
    repeat (3) idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
